// File: rtl/miinst_dispatch_queue_pkg.sv
// Shared types and helpers for the micro-instruction dispatch queue.
//   miinst_t / miop_t : micro-instruction format and opcodes (MIOP_NOP = empty slot)
//   `MQ_N             : slots per fetch bundle (defaults to 4)
//   nop()             : canonical NOP micro-instruction
//   nz_mask()         : per-slot non-NOP mask of a bundle
//   lowest_set_idx()  : priority encoder, lowest set bit -> slot index
//   dispatch_entry_t  : one bundle FIFO entry (bundle + its nz mask)
`ifndef MQ_N
`define MQ_N 4
`endif

package miinst_dispatch_queue_pkg;

  localparam int unsigned MQ_N      = `MQ_N;
  localparam int unsigned MQ_SLOT_W = (MQ_N > 1) ? $clog2(MQ_N) : 1;

  typedef enum logic [2:0] {
    MIOP_NOP    = 3'd0,
    MIOP_ARITH  = 3'd1,
    MIOP_LOAD   = 3'd2,
    MIOP_STORE  = 3'd3,
    MIOP_BRANCH = 3'd4,
    MIOP_CMP    = 3'd5
  } miop_t;

  typedef struct packed {
    miop_t       op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } miinst_t;

  typedef miinst_t [MQ_N-1:0] mq_bundle_t;

  typedef struct packed {
    mq_bundle_t        bundle;
    logic [MQ_N-1:0]   nz;
  } dispatch_entry_t;

  function automatic miinst_t nop(input logic [15:0] tag);
    miinst_t m;
    m     = '0;
    m.op  = MIOP_NOP;
    m.imm = tag;
    return m;
  endfunction

  function automatic logic [MQ_N-1:0] nz_mask(input mq_bundle_t b);
    logic [MQ_N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MQ_N; i++) m[i] = (b[i].op != MIOP_NOP);
    return m;
  endfunction

  function automatic logic [MQ_SLOT_W-1:0] lowest_set_idx(input logic [MQ_N-1:0] mask);
    logic [MQ_SLOT_W-1:0] idx;
    idx = '0;
    // Scan downwards so the lowest set bit wins.
    for (int unsigned i = MQ_N; i > 0; i--)
      if (mask[i-1]) idx = MQ_SLOT_W'(i-1);
    return idx;
  endfunction

endpackage

// File: rtl/miinst_dispatch_queue_fifo.sv
// miinst_bundle_fifo: bundle storage for the dispatch queue.
//   push/wr_entry : write an entry (ignored during flush)
//   pop           : retire the head entry (ignored during flush)
//   flush         : synchronous clear of pointers and occupancy
//   head_bundle   : bundle of the head entry
//   next_nz       : nz mask of the entry behind the head (valid when occupancy > 1)
//   occupancy     : entries held
module miinst_bundle_fifo
  import miinst_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  dispatch_entry_t         wr_entry,
  input  logic                    pop,
  input  logic                    flush,
  output mq_bundle_t              head_bundle,
  output logic [MQ_N-1:0]         next_nz,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  dispatch_entry_t  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop  && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head_bundle = mem[rd_ptr].bundle;
  assign next_nz     = mem[rd_ptr + PTR_W'(1)].nz;

endmodule

// File: rtl/miinst_dispatch_queue.sv
// miinst_dispatch_queue: buffers fetch bundles and issues their non-NOP slots
// one per handshake, lowest slot first.
//   clk, rstn                       : clock, async active-low reset
//   in_valid/in_ready/in_miinst     : bundle input from fetch
//   flush                           : synchronous pipeline flush (highest priority)
//   out_valid/out_ready/out_miinst  : micro-op issue handshake
//   out_slot, out_last              : source slot, last non-NOP slot of the bundle
//   occupancy                       : bundles held, including the head
// Optional (`define MIQ_PERF_CNT_EN): perf_issued, perf_stall 32-bit counters.
module miinst_dispatch_queue
  import miinst_dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SLOT_W = MQ_SLOT_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  miinst_t [MQ_N-1:0]      in_miinst,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output miinst_t                 out_miinst,
  output logic [SLOT_W-1:0]       out_slot,
  output logic                    out_last,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef MIQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_stall
`endif
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  mq_bundle_t           head_bundle;
  logic [MQ_N-1:0]      next_nz;
  logic [MQ_N-1:0]      in_nz;
  logic [MQ_N-1:0]      rem_mask;
  logic [MQ_N-1:0]      rem_nxt;
  logic [MQ_N-1:0]      sel_onehot;
  logic [MQ_SLOT_W-1:0] sel;
  logic                 head_valid;
  logic                 push;
  logic                 pop;
  logic                 issue;
  dispatch_entry_t      wr_entry;

  assign in_nz    = nz_mask(in_miinst);
  assign wr_entry = '{bundle: in_miinst, nz: in_nz};

  assign in_ready   = (occupancy != OCC_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign head_valid = (occupancy != '0);

  assign sel        = lowest_set_idx(rem_mask);
  assign sel_onehot = MQ_N'(1) << sel;

  assign out_valid  = head_valid && (rem_mask != '0);
  assign out_slot   = SLOT_W'(sel);
  assign out_last   = (rem_mask != '0) && ((rem_mask & (rem_mask - 1'b1)) == '0);
  assign out_miinst = out_valid ? head_bundle[sel] : nop(16'd0);

  assign issue = out_valid && out_ready;
  // An all-NOP head (rem_mask == 0) retires on its own; otherwise the head
  // retires together with the handshake of its last slot.
  assign pop   = head_valid && ((rem_mask == '0) || (issue && out_last));

  miinst_bundle_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push        (push),
    .wr_entry    (wr_entry),
    .pop         (pop),
    .flush       (flush),
    .head_bundle (head_bundle),
    .next_nz     (next_nz),
    .occupancy   (occupancy)
  );

  // rem_mask is refilled on the same edge the head changes so issue continues
  // without a bubble; when the queue holds only the head, the new head is the
  // bundle being pushed in this cycle (if any).
  always_comb begin
    rem_nxt = rem_mask;
    if (flush)
      rem_nxt = '0;
    else if (pop)
      rem_nxt = (occupancy > OCC_W'(1)) ? next_nz : (push ? in_nz : '0);
    else if (push && !head_valid)
      rem_nxt = in_nz;
    else if (issue)
      rem_nxt = rem_mask & ~sel_onehot;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rem_mask <= '0;
    else       rem_mask <= rem_nxt;
  end

`ifdef MIQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue)                   perf_issued <= perf_issued + 32'd1;
      if (out_valid && !out_ready) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_miinst_dispatch_queue.sv
module tb_miinst_dispatch_queue;
  import miinst_dispatch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  mq_bundle_t        in_miinst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  miinst_t           out_miinst;
  logic [MQ_SLOT_W-1:0] out_slot;
  logic              out_last;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef MIQ_PERF_CNT_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_stall;
`endif

  miinst_dispatch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_miinst  (in_miinst),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_miinst (out_miinst),
    .out_slot   (out_slot),
    .out_last   (out_last),
    .occupancy  (occupancy)
`ifdef MIQ_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of whole bundles plus the list of slot indices
  // still to be issued from the head bundle.
  mq_bundle_t  mq[$];
  int          hr[$];
  int unsigned m_issued = 0;
  int unsigned m_stall  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic miinst_t mk(input miop_t op, input int rd, input int imm);
    miinst_t m;
    m = '0;
    m.op  = op;
    m.rd  = 5'(rd);
    m.rs1 = 5'(rd + 1);
    m.rs2 = 5'(rd + 2);
    m.imm = 16'(imm);
    return m;
  endfunction

  function automatic mq_bundle_t rand_bundle();
    mq_bundle_t b;
    for (int i = 0; i < int'(MQ_N); i++) begin
      if ($urandom_range(0, 1) == 0) b[i] = nop(16'd0);
      else b[i] = mk(miop_t'($urandom_range(1, 5)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 65535)));
    end
    return b;
  endfunction

  function automatic void load_head();
    hr.delete();
    if (mq.size() > 0)
      for (int i = 0; i < int'(MQ_N); i++)
        if (mq[0][i].op != MIOP_NOP) hr.push_back(i);
  endfunction

  function automatic void model_reset();
    mq.delete();
    hr.delete();
    m_issued = 0;
    m_stall  = 0;
  endfunction

  function automatic void model_edge(input logic iv, input mq_bundle_t b,
                                     input logic fl, input logic rdy);
    bit ev, accept, popped;
    int sz0;
    ev = (mq.size() > 0) && (hr.size() > 0);
    if (ev && rdy)  m_issued++;
    if (ev && !rdy) m_stall++;
    if (fl) begin
      mq.delete();
      hr.delete();
      return;
    end
    sz0    = mq.size();
    accept = iv && (sz0 != int'(DEPTH));
    popped = 0;
    if (sz0 > 0) begin
      if (hr.size() == 0) popped = 1;
      else if (rdy) begin
        void'(hr.pop_front());
        if (hr.size() == 0) popped = 1;
      end
    end
    if (popped) void'(mq.pop_front());
    if (accept) mq.push_back(b);
    if (popped || (sz0 == 0 && accept)) load_head();
  endfunction

  task automatic compare();
    bit      ev;
    int      es;
    miinst_t em;
    ev = (mq.size() > 0) && (hr.size() > 0);
    es = 0;
    em = nop(16'd0);
    if (ev) begin
      es = hr[0];
      em = mq[0][hr[0]];
    end
    chk("out_valid",  64'(out_valid),  64'(ev));
    chk("in_ready",   64'(in_ready),   64'(mq.size() != int'(DEPTH)));
    chk("occupancy",  64'(occupancy),  64'(mq.size()));
    chk("out_slot",   64'(out_slot),   64'(es));
    chk("out_last",   64'(out_last),   64'(ev && hr.size() == 1));
    chk("out_miinst", 64'(out_miinst), 64'(em));
`ifdef MIQ_PERF_CNT_EN
    chk("perf_issued", 64'(perf_issued), 64'(m_issued));
    chk("perf_stall",  64'(perf_stall),  64'(m_stall));
`endif
  endtask

  // Called at a falling edge: drive, advance the model, clock, then compare.
  task automatic step(input logic iv, input mq_bundle_t b, input logic fl, input logic rdy);
    in_valid  = iv;
    in_miinst = b;
    flush     = fl;
    out_ready = rdy;
    model_edge(iv, b, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  mq_bundle_t b1, ballnop, bs2, bfill, b3, zb;
  miinst_t    m_load, m_arith, m_store;

  initial begin
    zb        = '0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_miinst = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_occupancy",  64'(occupancy),  64'd0);
    chk("rst_out_slot",   64'(out_slot),   64'd0);
    chk("rst_out_last",   64'(out_last),   64'd0);
    chk("rst_out_miinst", 64'(out_miinst), 64'(nop(16'd0)));
    rstn = 1'b1;
    #1;
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    @(negedge clk);
    compare();

    // Bundle with LOAD/ARITH/STORE in slots 1..3
    m_load  = mk(MIOP_LOAD, 1, 16'h0011);
    m_arith = mk(MIOP_ARITH, 2, 16'h0022);
    m_store = mk(MIOP_STORE, 3, 16'h0033);
    b1[0] = nop(16'd0); b1[1] = m_load; b1[2] = m_arith; b1[3] = m_store;
    step(1'b1, b1, 1'b0, 1'b1);
    chk("t1_valid_c1", 64'(out_valid), 64'd1);
    chk("t1_slot_c1",  64'(out_slot),  64'd1);
    chk("t1_last_c1",  64'(out_last),  64'd0);
    chk("t1_inst_c1",  64'(out_miinst), 64'(m_load));
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t1_slot_c2",  64'(out_slot),  64'd2);
    chk("t1_last_c2",  64'(out_last),  64'd0);
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t1_slot_c3",  64'(out_slot),  64'd3);
    chk("t1_last_c3",  64'(out_last),  64'd1);
    chk("t1_inst_c3",  64'(out_miinst), 64'(m_store));
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t1_valid_c4", 64'(out_valid), 64'd0);
    chk("t1_occ_c4",   64'(occupancy), 64'd0);

    // All-NOP bundle followed by a slot-2-only bundle
    for (int i = 0; i < int'(MQ_N); i++) ballnop[i] = nop(16'd0);
    bs2 = ballnop;
    bs2[2] = mk(MIOP_ARITH, 7, 16'h0707);
    step(1'b1, ballnop, 1'b0, 1'b1);
    chk("t2_valid_c1", 64'(out_valid), 64'd0);
    chk("t2_occ_c1",   64'(occupancy), 64'd1);
    step(1'b1, bs2, 1'b0, 1'b1);
    chk("t2_valid_c2", 64'(out_valid), 64'd1);
    chk("t2_slot_c2",  64'(out_slot),  64'd2);
    chk("t2_last_c2",  64'(out_last),  64'd1);
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t2_occ_end",  64'(occupancy), 64'd0);

    // Fill to DEPTH with out_ready low, then drain
    for (int k = 0; k < int'(DEPTH) + 1; k++) begin
      bfill = ballnop;
      bfill[0] = mk(MIOP_LOAD, k, 16'h0100 + k);
      bfill[3] = mk(MIOP_STORE, k, 16'h0300 + k);
      step(1'b1, bfill, 1'b0, 1'b0);
    end
    chk("t3_in_ready", 64'(in_ready),   64'd0);
    chk("t3_occ_full", 64'(occupancy),  64'd4);
    chk("t3_held",     64'(out_miinst), 64'(mk(MIOP_LOAD, 0, 16'h0100)));
    for (int k = 0; k < 2 * int'(DEPTH); k++) step(1'b0, zb, 1'b0, 1'b1);
    chk("t3_drained",  64'(occupancy),  64'd0);

    // Flush with three bundles held, mid-bundle, and an incoming bundle
    b3 = ballnop;
    b3[0] = mk(MIOP_ARITH, 4, 16'h0404);
    b3[1] = mk(MIOP_CMP, 5, 16'h0505);
    b3[2] = mk(MIOP_BRANCH, 6, 16'h0606);
    for (int k = 0; k < 3; k++) step(1'b1, b3, 1'b0, 1'b0);
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t4_mid_slot", 64'(out_slot),  64'd1);
    step(1'b1, b3, 1'b1, 1'b1);
    chk("t4_valid",    64'(out_valid), 64'd0);
    chk("t4_occ",      64'(occupancy), 64'd0);
    chk("t4_in_ready", 64'(in_ready),  64'd1);
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t4_lost",     64'(occupancy), 64'd0);

    // Streaming 3-slot bundles every 3 cycles: no bubbles
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        step(c == 0, b3, 1'b0, 1'b1);
        chk("t5_no_bubble", 64'(out_valid), 64'd1);
        chk("t5_occ_le1",   64'(occupancy > 1), 64'd0);
      end
    end
    step(1'b0, zb, 1'b0, 1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 55, rand_bundle(), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 70);
    end

    // Asynchronous reset mid-issue
    step(1'b1, b3, 1'b0, 1'b1);
    step(1'b0, zb, 1'b0, 1'b1);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'd0);
    chk("t6_async_occ",   64'(occupancy), 64'd0);
`ifdef MIQ_PERF_CNT_EN
    chk("t6_perf_clr",    64'(perf_issued), 64'd0);
`endif
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    in_valid = 1'b0;
    compare();
    chk("t6_occ_after",   64'(occupancy), 64'd0);
    for (int c = 0; c < 200; c++) begin
      step($urandom_range(0, 1) == 1, rand_bundle(), 1'b0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miinst_dispatch_queue.md
Name: miinst_dispatch_queue

Overview:
- Consumer end of the fetch-phase micro-instruction interface. Fetch/decode emits one bundle per instruction: `miinst_t[MQ_N]` slots plus a `valid` strobe.
- This block buffers bundles in a FIFO and drains each bundle slot by slot, in ascending slot index order. NOP slots are skipped.
- Each non-NOP micro-instruction is issued to the execute stage over a valid/ready handshake.
- Sits between fetch_phase_* and the execute/register-read stage.

Parameters:
- DEPTH, 4, bundle FIFO entries; power of two, ≥2.
- SLOT_W, $clog2(`MQ_N), width of the slot index output.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch bundle strobe (the decoder's valid).
- in_ready  out  1  FIFO can accept a bundle this cycle.
- in_miinst  in  miinst_t[`MQ_N]  bundle from fetch.
- flush  in  1  synchronous pipeline flush (mispredict/jr redirect).
- out_valid  out  1  out_miinst holds an issuable micro-instruction.
- out_ready  in  1  execute stage accepts.
- out_miinst  out  miinst_t  issued micro-instruction.
- out_slot  out  SLOT_W  slot index it came from.
- out_last  out  1  last non-NOP slot of its bundle (instruction retire marker).
- occupancy  out  $clog2(DEPTH)+1  bundles held, including the head.

Behaviour:
- Reset: FIFO empty, rd/wr pointers 0, rem_mask 0, occupancy 0, out_valid 0, out_slot 0, out_last 0, out_miinst = nop(0). in_ready = 1 after reset deassertion. Reset mid-issue discards everything.
- NOP definition: slot with `.op == MIOP_NOP`.
- On accept, each entry stores the bundle plus nz_mask[`MQ_N] (bit i = slot i non-NOP).
- Accept: in_valid && in_ready. in_ready = (occupancy != DEPTH), a function of registered state only. No same-cycle pop-through when full: a full FIFO rejects even if the head pops that cycle.
- Head register rem_mask: loaded with the head entry's nz_mask when the head becomes valid.
- Issue select is combinational: lowest set bit of rem_mask.
  - out_valid = head present && rem_mask != 0.
  - out_slot = that bit index; out_miinst = head.bundle[out_slot].
  - out_last = exactly one bit set in rem_mask.
- Issue handshake: on out_valid && out_ready, clear the selected bit. If that was the last bit, pop the head and load rem_mask from the next entry in the same edge, so back-to-back issue runs at one micro-op per cycle across bundle boundaries.
- All-NOP bundle (nz_mask == 0): popped in the cycle after it reaches the head, never issued, out_valid 0 that cycle.
- Latency: bundle accepted at edge N into an empty FIFO → first slot presented with out_valid = 1 in cycle N+1.
- Stall: while out_valid && !out_ready, out_miinst, out_slot and out_last are held stable.
- Flush (priority over all):
  - Next edge: empty the FIFO, rem_mask = 0, out_valid = 0.
  - An in_valid bundle in the flush cycle is dropped.
  - in_ready remains 1 during flush.
- Simultaneous push and pop: occupancy unchanged.
- Pointers wrap modulo DEPTH.

Optional Feature:
- MIQ_PERF_CNT_EN.
  - Defined: adds output `perf_issued` (32-bit) and `perf_stall` (32-bit), reset 0, cleared by neither flush nor wrap (both wrap modulo 2^32).
    - perf_issued counts issue handshakes.
    - perf_stall counts cycles with out_valid && !out_ready.
  - Undefined: ports and counters absent; functionality otherwise identical.

Decomposition:
- Shared package/header, alongside miinst_t, MIOP_*, `MQ_N and the nop() function: the nz-mask helper, the priority-encode function (lowest set bit → index), and a dispatch_entry_t struct {miinst_t[`MQ_N] bundle; logic[`MQ_N-1:0] nz}.
- One sub-module, miinst_bundle_fifo: parameterised storage, pointers, occupancy and flush.
- The issue/rem_mask logic stays in the top.

Test Plan:
- Reset then push one bundle, slots 1 (LOAD), 2 (ARITH), 3 (STORE) non-NOP, rest NOP, out_ready = 1 → out_slot 1, 2, 3 on consecutive cycles starting 1 cycle after accept; out_last = 1 only with slot 3.
- Push an all-NOP bundle (reg-reg CMP with no store, nothing else) followed by a bundle with only slot 2 → no issue for the first bundle; slot 2 issues at cycle 2 after the first accept; occupancy returns to 0.
- Fill with DEPTH = 4 bundles while out_ready = 0 → in_ready = 0 and occupancy = 4; the 5th in_valid is not accepted; out_miinst held stable; release out_ready → all slots drain in order.
- Assert flush while 3 bundles are held, mid-bundle, with in_valid = 1 the same cycle → next cycle out_valid = 0, occupancy = 0, the incoming bundle lost.
- Continuous streaming of 3-slot bundles at one bundle every 3 cycles with out_ready = 1 → 100% issue rate, no bubble at bundle boundaries, occupancy ≤ 1.
- Drop rstn asynchronously mid-issue (between clock edges) → out_valid = 0 immediately, and occupancy = 0 after release. With MIQ_PERF_CNT_EN defined, perf_issued equals the handshake count before reset, then 0.
